shaft_pulse_meter: RTL and testbench

Feedback-side companion to the H-bridge drive path. Reads the left and right wheel shaft-encoder pulse inputs (`shaftPulseL`, `shaftPulseR`) and, for each wheel, produces:
- a per-window speed count,
- a free-running odometry count,
- a stall flag.

The drive state machine consumes these to close the loop on the PWM it sends out.

---
 rtl/shaft_pulse_meter_if.sv | 28 ++
 rtl/shaft_pulse_meter.sv | 127 ++++++++++++
 tb/tb_shaft_pulse_meter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shaft_pulse_meter_if.sv
// Signal bundle between the wheel encoders / drive FSM and shaft_pulse_meter.
// The master side drives the encoder and control inputs; the slave side is the meter.
interface shaft_pulse_meter_if #(
   parameter int SPEED_W = 16,
   parameter int ODO_W   = 24
);
   logic               shaftPulseL;
   logic               shaftPulseR;
   logic               driveActive;
   logic               clearOdo;
   logic [SPEED_W-1:0] speedL;
   logic [SPEED_W-1:0] speedR;
   logic               speedValid;
   logic [ODO_W-1:0]   odoL;
   logic [ODO_W-1:0]   odoR;
   logic               stallL;
   logic               stallR;

   modport master (
      output shaftPulseL, shaftPulseR, driveActive, clearOdo,
      input  speedL, speedR, speedValid, odoL, odoR, stallL, stallR
   );

   modport slave (
      input  shaftPulseL, shaftPulseR, driveActive, clearOdo,
      output speedL, speedR, speedValid, odoL, odoR, stallL, stallR
   );
endinterface

// File: rtl/shaft_pulse_meter.sv
// Per-wheel speed, odometry and stall measurement from debounced shaft-encoder pulses.
// Input edge to pulse event takes 2 + DEBOUNCE_CYCLES cycles; speed/stall refresh once per window.
module shaft_pulse_meter #(
   parameter int WINDOW_CYCLES   = 5_000_000,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int STALL_WINDOWS   = 3,
   parameter int SPEED_W         = 16,
   parameter int ODO_W           = 24
) (
   input  logic                clk,
   input  logic                rstN,
   shaft_pulse_meter_if.slave  bus
);
   localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int ZC_W  = $clog2(STALL_WINDOWS + 1);

   localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ZC_W-1:0]    ZC_MAX    = ZC_W'(STALL_WINDOWS);
   localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

   // Channel index 0 is the left wheel, 1 is the right wheel.
   logic [1:0]         pin;
   logic [1:0]         sync1_q, sync1_d;
   logic [1:0]         sync2_q, sync2_d;
   logic [1:0]         stable_q, stable_d;
   logic [1:0]         pulse_q, pulse_d;
   logic [1:0]         stall_q, stall_d;
   logic [DB_W-1:0]    db_q[2], db_d[2];
   logic [SPEED_W-1:0] acc_q[2], acc_d[2];
   logic [SPEED_W-1:0] speed_q[2], speed_d[2];
   logic [ODO_W-1:0]   odo_q[2], odo_d[2];
   logic [ZC_W-1:0]    zc_q[2], zc_d[2];
   logic [WIN_W-1:0]   win_q, win_d;
   logic               speed_vld_q, speed_vld_d;
   logic               terminal;
   logic [SPEED_W-1:0] closing[2];

   assign pin = {bus.shaftPulseR, bus.shaftPulseL};

   always_comb begin
      terminal    = (win_q == WIN_LAST);
      win_d       = terminal ? '0 : win_q + WIN_W'(1);
      speed_vld_d = terminal;
      sync1_d     = pin;
      sync2_d     = sync1_q;
      stable_d    = stable_q;
      pulse_d     = '0;
      stall_d     = stall_q;
      for (int ch = 0; ch < 2; ch++) begin
         db_d[ch]    = '0;
         if (sync2_q[ch] != stable_q[ch]) begin
            if (db_q[ch] == DB_LAST) begin
               stable_d[ch] = sync2_q[ch];
               pulse_d[ch]  = sync2_q[ch];
            end else begin
               db_d[ch] = db_q[ch] + DB_W'(1);
            end
         end
         // A pulse on the terminal cycle belongs to the window that is closing.
         closing[ch] = (pulse_q[ch] && acc_q[ch] != SPEED_MAX) ? acc_q[ch] + SPEED_W'(1) : acc_q[ch];
         acc_d[ch]   = closing[ch];
         speed_d[ch] = speed_q[ch];
         zc_d[ch]    = zc_q[ch];
         if (terminal) begin
            acc_d[ch]   = '0;
            speed_d[ch] = closing[ch];
            if (!bus.driveActive || closing[ch] != '0) begin
               zc_d[ch] = '0;
            end else if (zc_q[ch] != ZC_MAX) begin
               zc_d[ch] = zc_q[ch] + ZC_W'(1);
            end
            stall_d[ch] = (zc_d[ch] == ZC_MAX);
         end
         if (bus.clearOdo) begin
            odo_d[ch] = '0;
         end else if (pulse_q[ch]) begin
            odo_d[ch] = odo_q[ch] + ODO_W'(1);
         end else begin
            odo_d[ch] = odo_q[ch];
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         stable_q    <= '0;
         pulse_q     <= '0;
         stall_q     <= '0;
         win_q       <= '0;
         speed_vld_q <= 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            db_q[ch]    <= '0;
            acc_q[ch]   <= '0;
            speed_q[ch] <= '0;
            odo_q[ch]   <= '0;
            zc_q[ch]    <= '0;
         end
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         stable_q    <= stable_d;
         pulse_q     <= pulse_d;
         stall_q     <= stall_d;
         win_q       <= win_d;
         speed_vld_q <= speed_vld_d;
         for (int ch = 0; ch < 2; ch++) begin
            db_q[ch]    <= db_d[ch];
            acc_q[ch]   <= acc_d[ch];
            speed_q[ch] <= speed_d[ch];
            odo_q[ch]   <= odo_d[ch];
            zc_q[ch]    <= zc_d[ch];
         end
      end
   end

   assign bus.speedL     = speed_q[0];
   assign bus.speedR     = speed_q[1];
   assign bus.speedValid = speed_vld_q;
   assign bus.odoL       = odo_q[0];
   assign bus.odoR       = odo_q[1];
   assign bus.stallL     = stall_q[0];
   assign bus.stallR     = stall_q[1];
endmodule

// File: tb/tb_shaft_pulse_meter.sv
// Randomized bench for shaft_pulse_meter: a level/run-length model predicts each window's
// speed, stall and odometry; a monitor compares on every speedValid and checks output hold.
module tb_shaft_pulse_meter;
   localparam int W     = 100;
   localparam int D     = 4;
   localparam int S     = 3;
   localparam int OW    = 5;
   localparam int NCYC1 = 100 * 40 + 50;
   localparam int NCYC2 = 100 * 15 + 50;

   typedef struct packed {
      int          cyc;
      logic [15:0] spdL;
      logic [15:0] spdR;
      logic        stL;
      logic        stR;
      logic [OW-1:0] odoL;
      logic [OW-1:0] odoR;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   shaft_pulse_meter_if #(.SPEED_W(16), .ODO_W(OW)) bus ();

   shaft_pulse_meter #(
      .WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(D), .STALL_WINDOWS(S), .SPEED_W(16), .ODO_W(OW)
   ) dut (
      .clk (clk),
      .rstN(rst_n),
      .bus (bus)
   );

   int   cyc;
   int   n_vec;
   int   n_err;
   exp_t exp_q[$];
   exp_t mon_e;
   exp_t last_e;

   // Model state: ev[ch][c] marks a pulse event in cycle c (counted by the edge ending c).
   bit          ev[2][8192];
   bit          clr[8192];
   bit          dav[8192];
   int          gen_left[2];
   bit          gen_lvl[2];
   int          next_len[2];
   bit          prev_lvl[2];
   int          run[2];
   bit          acc_lvl[2];
   logic [OW-1:0] m_odo[2];
   int          zc[2];
   int          last_c;
   bit          ph1;
   bit          clr_done;
   bit          da;

   function automatic int pick();
      int r;
      r = $urandom_range(0, 19);
      if (r < 4)  return $urandom_range(1, D - 1);
      if (r < 15) return $urandom_range(D, 12);
      if (r < 18) return $urandom_range(20, 60);
      return $urandom_range(150, 350);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 8192; c++) begin
         ev[0][c] = 1'b0;
         ev[1][c] = 1'b0;
         clr[c]   = 1'b0;
         dav[c]   = 1'b0;
      end
      for (int ch = 0; ch < 2; ch++) begin
         gen_lvl[ch]  = 1'b0;
         gen_left[ch] = pick();
         next_len[ch] = 0;
         prev_lvl[ch] = 1'b0;
         run[ch]      = D + 1;
         acc_lvl[ch]  = 1'b0;
         m_odo[ch]    = '0;
         zc[ch]       = 0;
      end
      last_c = -1;
      da     = 1'b1;
   endtask

   task automatic close_window();
      exp_t e;
      int   cnt[2];
      for (int c = last_c + 1; c <= cyc; c++) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (clr[c])          m_odo[ch] = '0;
            else if (ev[ch][c])  m_odo[ch] = m_odo[ch] + OW'(1);
         end
      end
      last_c = cyc;
      for (int ch = 0; ch < 2; ch++) begin
         cnt[ch] = 0;
         for (int c = cyc - W + 1; c <= cyc; c++) cnt[ch] += int'(ev[ch][c]);
         if (!dav[cyc])        zc[ch] = 0;
         else if (cnt[ch] == 0) zc[ch] = (zc[ch] < S) ? zc[ch] + 1 : S;
         else                  zc[ch] = 0;
      end
      e.cyc  = cyc + 1;
      e.spdL = 16'((cnt[0] > 65535) ? 65535 : cnt[0]);
      e.spdR = 16'((cnt[1] > 65535) ? 65535 : cnt[1]);
      e.stL  = (zc[0] == S);
      e.stR  = (zc[1] == S);
      e.odoL = m_odo[0];
      e.odoR = m_odo[1];
      exp_q.push_back(e);
   endtask

   task automatic step();
      bit lv[2];
      bit c;
      for (int ch = 0; ch < 2; ch++) begin
         if (gen_left[ch] == 0) begin
            gen_lvl[ch]  = !gen_lvl[ch];
            gen_left[ch] = (next_len[ch] > 0) ? next_len[ch] : pick();
            next_len[ch] = 0;
         end
         gen_left[ch]--;
         lv[ch] = gen_lvl[ch];
      end
      // Phase 1: hold the left wheel still while driving (stall), then while not driving.
      if (ph1 && ((cyc >= 300 && cyc < 700) || (cyc >= 800 && cyc < 1200))) lv[0] = 1'b0;
      if (ph1 && cyc < 800)                    da = 1'b1;
      else if (ph1 && cyc < 1200)              da = 1'b0;
      else if ($urandom_range(0, 249) == 0)    da = !da;
      c = ($urandom_range(0, 699) == 0);
      if (ph1 && !clr_done && cyc >= 200 && cyc < 300 && ev[0][cyc]) begin
         c        = 1'b1;
         clr_done = 1'b1;
      end
      bus.shaftPulseL = lv[0];
      bus.shaftPulseR = lv[1];
      bus.driveActive = da;
      bus.clearOdo    = c;
      clr[cyc] = c;
      dav[cyc] = da;
      // A level is accepted once it has been driven for D consecutive cycles;
      // the resulting event lands 3 cycles after the last of those D cycles.
      for (int ch = 0; ch < 2; ch++) begin
         if (lv[ch] == prev_lvl[ch]) run[ch]++;
         else                        run[ch] = 1;
         prev_lvl[ch] = lv[ch];
         if (run[ch] == D && lv[ch] != acc_lvl[ch]) begin
            acc_lvl[ch] = lv[ch];
            if (lv[ch]) ev[ch][cyc + 3] = 1'b1;
         end
      end
      if (cyc % W == W - 1) close_window();
   endtask

   task automatic idle_inputs();
      bus.shaftPulseL = 1'b0;
      bus.shaftPulseR = 1'b0;
      bus.driveActive = 1'b0;
      bus.clearOdo    = 1'b0;
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      cyc      = 0;
      clr_done = 1'b0;
      rst_n    = 1'b1;
      idle_inputs();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      ph1 = 1'b1;
      model_reset();
      // Left pulse rises at cycle 93 so its event lands on terminal cycle 99.
      gen_lvl[0]  = 1'b0;
      gen_left[0] = 93;
      next_len[0] = 10;
      cyc = 0;
      step();
      for (int i = 1; i < NCYC1; i++) begin
         @(posedge clk); #1;
         cyc = i;
         step();
      end
      // Mid-window reset at window cycle 50.
      @(posedge clk); #1;
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      ph1 = 1'b0;
      model_reset();
      cyc = 0;
      step();
      for (int i = 1; i < NCYC2; i++) begin
         @(posedge clk); #1;
         cyc = i;
         step();
      end
      repeat (5) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         n_vec++;
         if (bus.speedL != 0 || bus.speedR != 0 || bus.speedValid || bus.odoL != 0 ||
             bus.odoR != 0 || bus.stallL || bus.stallR) begin
            n_err++;
            $display("FAIL reset_zero: got spdL=%0d spdR=%0d vld=%0d odoL=%0d odoR=%0d stL=%0d stR=%0d, want all 0",
                     bus.speedL, bus.speedR, bus.speedValid, bus.odoL, bus.odoR, bus.stallL, bus.stallR);
         end
         last_e = '0;
      end else if (bus.speedValid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: speedValid at cycle %0d, want no strobe", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (cyc != mon_e.cyc || bus.speedL != mon_e.spdL || bus.speedR != mon_e.spdR ||
                bus.stallL != mon_e.stL || bus.stallR != mon_e.stR ||
                bus.odoL != mon_e.odoL || bus.odoR != mon_e.odoR) begin
               n_err++;
               $display("FAIL window: got cyc=%0d spdL=%0d spdR=%0d stL=%0d stR=%0d odoL=%0d odoR=%0d, want cyc=%0d spdL=%0d spdR=%0d stL=%0d stR=%0d odoL=%0d odoR=%0d",
                        cyc, bus.speedL, bus.speedR, bus.stallL, bus.stallR, bus.odoL, bus.odoR,
                        mon_e.cyc, mon_e.spdL, mon_e.spdR, mon_e.stL, mon_e.stR, mon_e.odoL, mon_e.odoR);
            end
            last_e = mon_e;
         end
      end else begin
         n_vec++;
         if (bus.speedL != last_e.spdL || bus.speedR != last_e.spdR ||
             bus.stallL != last_e.stL || bus.stallR != last_e.stR) begin
            n_err++;
            $display("FAIL hold at cycle %0d: got spdL=%0d spdR=%0d stL=%0d stR=%0d, want spdL=%0d spdR=%0d stL=%0d stR=%0d",
                     cyc, bus.speedL, bus.speedR, bus.stallL, bus.stallR,
                     last_e.spdL, last_e.spdR, last_e.stL, last_e.stR);
         end
         if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_valid: no strobe by cycle %0d, want strobe at cycle %0d", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
   end
endmodule
